sort_load_ctrl: RTL and testbench

- Sequencer for the 32-entry strength register bank (29-bit slots: {index[4:0], bad, good, strength[21:0]}).
- Accepts per-image average-strength results from the upstream strength engine over a valid/ready handshake.
- Assigns each result a slot index 0..31 and generates the glitch-free write strobe the bank uses as its clock.
- Clears the bank at batch start and reports batch completion to the counting/sort stage.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_slot_cnt.sv | 33 +++
 rtl/sort_load_ctrl.sv | 116 +++++++++++
 tb/tb_sort_load_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and FSM state encoding for the strength-bank load sequencer.
package sort_pkg;

  localparam int N_ENTRIES = 32;
  localparam int IDX_W     = 5;
  localparam int STR_W     = 22;
  localparam int SLOT_W    = IDX_W + 2 + STR_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
  localparam logic [2:0] ST_HOLD   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/sort_slot_cnt.sv
// Slot index and written-slot count for one batch; the index stops at the last slot
// while the count still advances to N_ENTRIES.
module sort_slot_cnt
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W:0]   count,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  assign last = (index == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index <= '0;
      count <= '0;
    end else if (clr) begin
      index <= '0;
      count <= '0;
    end else if (inc) begin
      count <= count + (IDX_W + 1)'(1);
      if (!last) index <= index + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sort_load_ctrl.sv
// Batch sequencer for the 32-slot strength bank: clears the bank, accepts results,
// drives a glitch-free registered write strobe and reports completion.
module sort_load_ctrl
  import sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [STR_W-1:0] in_strength,
  input  logic             in_good,
  input  logic             in_bad,
  input  logic             slot_full,
  output logic             sort_clr,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic [STR_W-1:0] wr_strength,
  output logic             wr_good,
  output logic             wr_bad,
  output logic [IDX_W:0]   count,
  output logic             busy,
  output logic             done,
  output logic             err_flag
);

  logic [2:0] state, state_nx;
  logic       cnt_clr, cnt_inc, last, accept, done_wait;

  assign accept = (state == ST_LOAD) && in_valid && in_ready && !abort;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          state_nx = ST_CLEAR;
          cnt_clr  = 1'b1;
        end
        ST_CLEAR:  state_nx = ST_LOAD;
        ST_LOAD:   if (accept) state_nx = ST_SETUP;
        ST_SETUP:  state_nx = ST_STROBE;
        ST_STROBE: state_nx = ST_HOLD;
        ST_HOLD: begin
          cnt_inc  = 1'b1;
          state_nx = last ? ST_DONE : ST_LOAD;
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  sort_slot_cnt u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .index (wr_index),
    .count (count),
    .last  (last)
  );

  // Strobe-type outputs are decoded from the next state so each is a clean flop output;
  // abort during STROBE therefore lets the current high phase run to its edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      sort_clr    <= 1'b0;
      in_ready    <= 1'b0;
      wr_en       <= 1'b0;
      wr_strength <= '0;
      wr_good     <= 1'b0;
      wr_bad      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_flag    <= 1'b0;
      done_wait   <= 1'b0;
    end else begin
      state     <= state_nx;
      sort_clr  <= (state_nx == ST_CLEAR);
      in_ready  <= (state_nx == ST_LOAD);
      wr_en     <= (state_nx == ST_STROBE);
      busy      <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
      done_wait <= (state == ST_DONE) && (state_nx == ST_DONE);

      if (accept) begin
        wr_strength <= in_strength;
        wr_good     <= in_good & ~in_bad;
        wr_bad      <= in_bad;
        if (in_good && in_bad) err_flag <= 1'b1;
      end

      // done_wait marks the second DONE cycle, where a missing slot_full becomes an error.
      if (cnt_clr) begin
        done     <= 1'b0;
        err_flag <= 1'b0;
      end else if (abort) begin
        done <= 1'b0;
      end else if ((state == ST_DONE) && !done) begin
        if (slot_full) begin
          done <= 1'b1;
        end else if (done_wait) begin
          done     <= 1'b1;
          err_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sort_load_ctrl.sv
// Directed bench for sort_load_ctrl: full batches, flag conflict, abort, start-while-busy,
// slot_full timeout and asynchronous reset during SETUP.
module tb_sort_load_ctrl;
  import sort_pkg::*;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid, in_good, in_bad, slot_full;
  logic [STR_W-1:0] in_strength;
  logic             in_ready, sort_clr, wr_en, wr_good, wr_bad, busy, done, err_flag;
  logic [IDX_W-1:0] wr_index;
  logic [STR_W-1:0] wr_strength;
  logic [IDX_W:0]   count;

  int total = 0;
  int bad   = 0;

  sort_load_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_strength (in_strength),
    .in_good     (in_good),
    .in_bad      (in_bad),
    .slot_full   (slot_full),
    .sort_clr    (sort_clr),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_strength (wr_strength),
    .wr_good     (wr_good),
    .wr_bad      (wr_bad),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err_flag    (err_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [STR_W-1:0] str_of(input int i);
    return STR_W'(32'h00ABC + i * 32'h1111);
  endfunction

  // Start a batch from IDLE/DONE and walk through the single CLEAR cycle.
  task automatic do_start(input string b);
    slot_full = 1'b0;
    start     = 1'b1;
    tick;
    start = 1'b0;
    check({b, " clr_hi"},   32'(sort_clr), 32'd1);
    check({b, " cnt_zero"}, 32'(count),    32'd0);
    check({b, " idx_zero"}, 32'(wr_index), 32'd0);
    check({b, " done_clr"}, 32'(done),     32'd0);
    check({b, " err_clr"},  32'(err_flag), 32'd0);
    check({b, " busy"},     32'(busy),     32'd1);
    check({b, " rdy_lo"},   32'(in_ready), 32'd0);
    tick;
    check({b, " clr_lo"},   32'(sort_clr), 32'd0);
    check({b, " rdy_hi"},   32'(in_ready), 32'd1);
  endtask

  // Entered with the DUT in LOAD; returns sampled in the STROBE cycle.
  task automatic push_slot(input string b, input int i, input logic g, input logic bb,
                           input logic st, input logic exp_err);
    in_valid    = 1'b1;
    in_strength = str_of(i);
    in_good     = g;
    in_bad      = bb;
    start       = st;
    tick;
    start = 1'b0;
    check($sformatf("%s s%0d setup_rdy", b, i), 32'(in_ready),    32'd0);
    check($sformatf("%s s%0d setup_we", b, i),  32'(wr_en),       32'd0);
    check($sformatf("%s s%0d str", b, i),       32'(wr_strength), 32'(str_of(i)));
    check($sformatf("%s s%0d good", b, i),      32'(wr_good),     32'(g & ~bb));
    check($sformatf("%s s%0d bad", b, i),       32'(wr_bad),      32'(bb));
    check($sformatf("%s s%0d err", b, i),       32'(err_flag),    32'(exp_err));
    check($sformatf("%s s%0d no_clr", b, i),    32'(sort_clr),    32'd0);
    tick;
    check($sformatf("%s s%0d strobe_we", b, i), 32'(wr_en),       32'd1);
    check($sformatf("%s s%0d idx", b, i),       32'(wr_index),    32'(i));
    check($sformatf("%s s%0d str_hold", b, i),  32'(wr_strength), 32'(str_of(i)));
  endtask

  // From STROBE through HOLD to the next LOAD (or DONE after the last slot).
  task automatic finish_slot(input string b, input int i);
    tick;
    check($sformatf("%s s%0d hold_we", b, i),   32'(wr_en),    32'd0);
    check($sformatf("%s s%0d hold_cnt", b, i),  32'(count),    32'(i));
    tick;
    check($sformatf("%s s%0d cnt", b, i),       32'(count),    32'(i + 1));
    check($sformatf("%s s%0d next_rdy", b, i),  32'(in_ready), (i < 31) ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_good = 1'b0; in_bad = 1'b0; slot_full = 1'b0; in_strength = '0;
    tick; tick;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst sort_clr", 32'(sort_clr), 32'd0);
    check("rst wr_en",    32'(wr_en),    32'd0);
    check("rst wr_index", 32'(wr_index), 32'd0);
    check("rst count",    32'(count),    32'd0);
    check("rst busy",     32'(busy),     32'd0);
    check("rst done",     32'(done),     32'd0);
    check("rst err",      32'(err_flag), 32'd0);
    rst = 1'b1;
    tick;
    check("idle in_ready", 32'(in_ready), 32'd0);

    // Batch A: back-to-back, start ignored at slot 3, flag conflict at slot 5, slot_full modelled.
    do_start("A");
    for (int i = 0; i < 32; i++) begin
      push_slot("A", i, (i == 7) ? 1'b0 : (i % 3 != 1), (i == 5) || (i == 7),
                (i == 3), (i >= 5));
      if (i == 31) slot_full = 1'b1;
      finish_slot("A", i);
    end
    in_valid = 1'b0;
    check("A done_entry done", 32'(done), 32'd0);
    check("A done_entry busy", 32'(busy), 32'd0);
    tick;
    check("A done",        32'(done),     32'd1);
    check("A done count",  32'(count),    32'd32);
    check("A done idx",    32'(wr_index), 32'd31);
    check("A done rdy",    32'(in_ready), 32'd0);
    check("A done busy",   32'(busy),     32'd0);
    check("A err sticky",  32'(err_flag), 32'd1);
    tick;
    check("A done hold",   32'(done),     32'd1);
    check("A err hold",    32'(err_flag), 32'd1);

    // Batch B: abort while strobing slot 10.
    do_start("B");
    for (int i = 0; i < 10; i++) begin
      push_slot("B", i, 1'b1, 1'b0, 1'b0, 1'b0);
      finish_slot("B", i);
    end
    push_slot("B", 10, 1'b1, 1'b0, 1'b0, 1'b0);
    abort = 1'b1;
    tick;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("B abort we",    32'(wr_en),    32'd0);
    check("B abort rdy",   32'(in_ready), 32'd0);
    check("B abort busy",  32'(busy),     32'd0);
    check("B abort done",  32'(done),     32'd0);
    check("B abort count", 32'(count),    32'd10);
    check("B abort idx",   32'(wr_index), 32'd10);
    tick;
    check("B idle we",     32'(wr_en),    32'd0);
    check("B idle rdy",    32'(in_ready), 32'd0);

    // Batch C: slot_full never arrives, so DONE times out with an error.
    do_start("C");
    for (int i = 0; i < 32; i++) begin
      push_slot("C", i, i[0], 1'b0, 1'b0, 1'b0);
      finish_slot("C", i);
    end
    in_valid = 1'b0;
    check("C entry done", 32'(done),     32'd0);
    check("C entry err",  32'(err_flag), 32'd0);
    tick;
    check("C wait1 done", 32'(done),     32'd0);
    check("C wait1 err",  32'(err_flag), 32'd0);
    tick;
    check("C tmo done",   32'(done),     32'd1);
    check("C tmo err",    32'(err_flag), 32'd1);
    check("C tmo count",  32'(count),    32'd32);

    // Batch D: asynchronous reset while in SETUP.
    do_start("D");
    in_valid    = 1'b1;
    in_strength = 22'h3FFFFF;
    in_good     = 1'b0;
    in_bad      = 1'b1;
    tick;
    in_valid = 1'b0;
    check("D setup str", 32'(wr_strength), 32'h3FFFFF);
    check("D setup bad", 32'(wr_bad),      32'd1);
    check("D setup busy", 32'(busy),       32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("D arst str",   32'(wr_strength), 32'd0);
    check("D arst bad",   32'(wr_bad),      32'd0);
    check("D arst busy",  32'(busy),        32'd0);
    check("D arst count", 32'(count),       32'd0);
    check("D arst rdy",   32'(in_ready),    32'd0);
    check("D arst we",    32'(wr_en),       32'd0);
    tick;
    check("D arst hold busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick;
    check("D post idle rdy", 32'(in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
